instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Instruction prefetch buffer between the InstructionFetchPhase stage and the instruction decode stage.
- Decouples fetch from decode stalls: fetch pushes {PC, instruction} pairs, and decode pops them in order.
- A Flush input discards all buffered entries on a redirect (branch, jump or jump-register taken).
- Circular FIFO with valid/ready handshakes on both sides and an occupancy count.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, 2 or more.
- PTR_W, 2, log2(DEPTH); width of the read and write pointers.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  discard all entries; takes effect at the next rising edge.
- in_valid  input  1  fetch presents a valid entry.
- in_pc  input  32  PC of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept an entry this cycle.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction word of the head entry.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array {pc, instr}, plus write pointer wp, read pointer rp and count, all registered.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It is combinational from count only, never from out_ready, so there is no pass-through when full.
- out_valid = (count != 0).
- out_pc and out_instr show the entry at rp (show-ahead).
  - When count == 0, out_pc = 32'h0 and out_instr = 32'h00000000 (NOP).
- Latency: a push into an empty queue is visible on out_* in the cycle after the push edge. There is no combinational bypass from input to output.
- Push: write mem[wp] <= {in_pc, in_instr}; wp <= wp+1, wrapping modulo DEPTH.
- Pop: rp <= rp+1, wrapping modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged (legal whenever 0 < count < DEPTH)
- Full: in_ready = 0. A pop in that cycle frees a slot, and in_ready rises the next cycle.
- Empty: out_valid = 0, and out_ready is ignored. count never underflows or overflows.
- Flush, in priority order:
  1. Reset has highest priority; if Reset = 1, Flush is ignored.
  2. Otherwise, when Flush = 1 at an edge: wp <= 0, rp <= 0, count <= 0.
  3. Any push or pop in the Flush cycle is discarded. The handshake signals may still read as accepted, but the entry is not retained.
- After Flush, the queue is empty. in_ready = 1 in the next cycle, and the redirected fetch PC may be pushed then.
- Reset, when Reset = 1 at the rising edge:
  - wp = 0, rp = 0, count = 0.
  - Outputs after the edge: in_ready = 1, out_valid = 0, out_pc = 0, out_instr = 0.
  - Memory contents need not be cleared.
- Reset asserted mid-operation behaves identically; any buffered entries are lost.
- Ordering: entries leave in exactly the order they were pushed, including across pointer wrap-around.
- Inputs are sampled only on rising edges. No latches, and no outputs that depend combinationally on in_* or out_ready.

Test Plan:
- Reset:
  - Hold Reset=1 for 2 cycles with in_valid=1.
  - Required: count=0, out_valid=0, in_ready=1, out_instr=0, and no entry retained after release.
- Fill and drain:
  - With out_ready=0, push PCs 0x00, 0x04, 0x08, 0x0C with instrs 0x20080001..0x20080004.
  - Required: count goes 1..4 and in_ready=0 at count=4; a fifth push with PC 0x10 is not accepted.
  - Then set out_ready=1. Required: out_pc reads 0x00, 0x04, 0x08, 0x0C on consecutive cycles, then out_valid=0.
- Simultaneous push and pop with wrap-around:
  - Keep in_valid=1 and out_ready=1 for 10 cycles, starting at count=2.
  - Required: count stays 2, every PC emerges in order with no gaps or duplicates, and the pointers wrap past DEPTH-1.
- Flush mid-stream:
  - With 3 entries (PCs 0x10, 0x14, 0x18), assert Flush=1 together with in_valid=1 (PC 0x1C) and out_ready=1.
  - Required next cycle: count=0, out_valid=0.
  - Then push PC 0x40. Required: out_pc=0x40 one cycle later.
- Full boundary:
  - At count=4, assert out_ready=1 for one cycle while in_valid=1.
  - Required: no push in that cycle, count=3, and in_ready=1 the next cycle; the push then completes and count returns to 4.
- Reset versus Flush:
  - Assert Reset=1 and Flush=1 together with 2 entries buffered.
  - Required: reset state as above, and pointers at 0 in the following cycle.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode: {pc, instr} entries,
// show-ahead head, flush on redirect, occupancy count.
module instr_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 64;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Handshake flags depend only on the registered count, never on out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head      = mem[rp];
    assign out_pc    = out_valid ? head[63:32] : 32'h0;
    assign out_instr = out_valid ? head[31:0]  : 32'h0;

    // Pointer and occupancy state; reset outranks flush.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (Flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PTR_W'(1);
            if (pop)  rp <= rp + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a write during flush/reset lands in a slot that is never read as valid.
    always_ff @(posedge Clk) begin
        if (push) mem[wp] <= {in_pc, in_instr};
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue with hand-computed expectations.
module tb_instr_fetch_queue;

    logic        Clk;
    logic        Reset;
    logic        Flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Flush     (Flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'hDEAD_0000; in_instr = 32'h1234_5678;

        // Reset held two cycles with a pushing fetch
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        Reset = 1'b0; in_valid = 1'b0;
        tick();
        check("rst_no_retain", 32'(count), 32'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            push_one(32'(4 * i), 32'h2008_0001 + 32'(i));
            check($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        push_one(32'h10, 32'h2008_0005);
        check("fifth_rejected", 32'(count), 32'd4);
        check("full_head_pc", out_pc, 32'h0);

        // Drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_pc%0d", i), out_pc, 32'(4 * i));
            check($sformatf("drain_instr%0d", i), out_instr, 32'h2008_0001 + 32'(i));
            tick();
        end
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Simultaneous push/pop across pointer wrap
        push_one(32'h100, 32'hA000_0000);
        push_one(32'h104, 32'hA000_0001);
        check("wrap_start_count", 32'(count), 32'd2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_pc    = 32'h108 + 32'(4 * k);
            in_instr = 32'hA000_0002 + 32'(k);
            check($sformatf("wrap_head%0d", k), out_pc, 32'h100 + 32'(4 * k));
            tick();
            check($sformatf("wrap_count%0d", k), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        check("wrap_tail0", out_pc, 32'h128);
        check("wrap_tail0_instr", out_instr, 32'hA000_000A);
        tick();
        check("wrap_tail1", out_pc, 32'h12C);
        tick();
        check("wrap_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Flush with simultaneous push and pop
        push_one(32'h10, 32'hB000_0000);
        push_one(32'h14, 32'hB000_0001);
        push_one(32'h18, 32'hB000_0002);
        check("pre_flush_count", 32'(count), 32'd3);
        Flush = 1'b1; in_valid = 1'b1; in_pc = 32'h1C; in_instr = 32'hB000_0003; out_ready = 1'b1;
        tick();
        Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        push_one(32'h40, 32'hC000_0000);
        check("post_flush_pc", out_pc, 32'h40);
        check("post_flush_count", 32'(count), 32'd1);

        // Full boundary: pop while full does not admit the waiting push
        push_one(32'h44, 32'hC000_0001);
        push_one(32'h48, 32'hC000_0002);
        push_one(32'h4C, 32'hC000_0003);
        check("bound_full", 32'(count), 32'd4);
        in_valid = 1'b1; in_pc = 32'h50; in_instr = 32'hC000_0004; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bound_count3", 32'(count), 32'd3);
        check("bound_in_ready", 32'(in_ready), 32'd1);
        check("bound_head", out_pc, 32'h44);
        tick();
        in_valid = 1'b0;
        check("bound_refull", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bound_drain%0d", i), out_pc, 32'h44 + 32'(4 * i));
            tick();
        end
        check("bound_empty", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Reset together with Flush while holding entries
        push_one(32'h200, 32'hD000_0000);
        push_one(32'h204, 32'hD000_0001);
        check("rf_pre_count", 32'(count), 32'd2);
        Reset = 1'b1; Flush = 1'b1;
        tick();
        Reset = 1'b0; Flush = 1'b0;
        check("rf_count", 32'(count), 32'd0);
        check("rf_out_valid", 32'(out_valid), 32'd0);
        check("rf_in_ready", 32'(in_ready), 32'd1);
        check("rf_out_pc", out_pc, 32'h0);
        check("rf_out_instr", out_instr, 32'h0);
        push_one(32'h300, 32'hE000_0000);
        check("rf_push_pc", out_pc, 32'h300);
        check("rf_push_instr", out_instr, 32'hE000_0000);
        check("rf_push_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
